// File: rtl/ps2_receiver_if.sv
// Scan-code output bundle of ps2_receiver: byte, valid/ready handshake, error pulses.
`timescale 1ns/1ps
interface ps2_receiver_if;
  logic [7:0] code;
  logic       code_valid;
  logic       code_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  modport master (
    output code, code_valid, parity_err, frame_err, overflow,
    input  code_ready
  );

  modport slave (
    input  code, code_valid, parity_err, frame_err, overflow,
    output code_ready
  );
endinterface

// File: rtl/ps2_receiver.sv
// PS/2 frame receiver: synchroniser, start/data/parity/stop framing, watchdog.
// Macro PS2_RX_FIFO_EN adds a FIFO_DEPTH-entry first-word-fall-through output FIFO.
`timescale 1ns/1ps
module ps2_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          ps2_clk,
  input  logic          ps2_dat,
  ps2_receiver_if.master rx
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          r_s0_clk, r_s1_clk, r_clk_prev;
  logic          r_s0_dat, r_s1_dat;
  state_t        r_state;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_wdog;
  logic          r_perr, r_ferr;
  logic          w_fall, w_push;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_s0_clk   <= 1'b1;
      r_s1_clk   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_s0_dat   <= 1'b1;
      r_s1_dat   <= 1'b1;
    end else begin
      r_s0_clk   <= ps2_clk;
      r_s1_clk   <= r_s0_clk;
      r_clk_prev <= r_s1_clk;
      r_s0_dat   <= ps2_dat;
      r_s1_dat   <= r_s0_dat;
    end
  end

  assign w_fall = r_clk_prev & ~r_s1_clk;
  // Good byte: stop bit high and odd parity over data plus parity bit.
  assign w_push = (r_state == S_STOP) & w_fall & r_s1_dat & (^{r_shift, r_par});

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_wdog   <= '0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_wdog <= (w_fall || r_state == S_IDLE) ? '0 : r_wdog + 1'b1;
      unique case (r_state)
        S_IDLE: if (w_fall && !r_s1_dat) begin
          r_state  <= S_DATA;
          r_bitcnt <= '0;
        end
        S_DATA: if (w_fall) begin
          r_shift  <= {r_s1_dat, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 1'b1;
          if (r_bitcnt == 3'd7) r_state <= S_PARITY;
        end
        S_PARITY: if (w_fall) begin
          r_par   <= r_s1_dat;
          r_state <= S_STOP;
        end
        S_STOP: if (w_fall) begin
          r_state <= S_IDLE;
          if (!r_s1_dat)                r_ferr <= 1'b1;
          else if (!(^{r_shift, r_par})) r_perr <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
      // Watchdog only fires between edges; a fall in the same cycle restarts it instead.
      if (r_state != S_IDLE && !w_fall && r_wdog == TW'(TIMEOUT_CYCLES - 1)) begin
        r_state <= S_IDLE;
        r_ferr  <= 1'b1;
        r_wdog  <= '0;
      end
    end
  end

  assign rx.parity_err = r_perr;
  assign rx.frame_err  = r_ferr;

`ifdef PS2_RX_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0]   r_cnt;
  logic          r_ovf;
  logic          w_full, w_pop, w_wr;

  assign w_full = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_pop  = (r_cnt != '0) & rx.code_ready;
  assign w_wr   = w_push & (~w_full | w_pop);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_push & w_full & ~w_pop;
      if (w_wr) begin
        r_mem[r_wr] <= r_shift;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      unique case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign rx.code       = r_mem[r_rd];
  assign rx.code_valid = (r_cnt != '0);
  assign rx.overflow   = r_ovf;
`else
  logic [7:0] r_code;
  logic       r_code_valid;
  logic       w_unused;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_code       <= '0;
      r_code_valid <= 1'b0;
    end else begin
      r_code_valid <= w_push;
      if (w_push) r_code <= r_shift;
    end
  end

  assign w_unused      = rx.code_ready & (FIFO_DEPTH != 0);
  assign rx.code       = r_code;
  assign rx.code_valid = r_code_valid;
  assign rx.overflow   = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: directed frame table, random frames vs. a rule model,
// watchdog timing, mid-frame reset and (with PS2_RX_FIFO_EN) FIFO fill/overflow/drain.
`timescale 1ns/1ps
module tb_ps2_receiver;
  localparam int unsigned T    = 2000;
  localparam int          HALF = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;

  ps2_receiver_if rx();

  ps2_receiver #(.TIMEOUT_CYCLES(T), .FIFO_DEPTH(4)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .rx       (rx)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_valid = 0, n_perr = 0, n_ferr = 0, n_ovf = 0, n_wide = 0;
  logic [7:0] obs[$];
  logic p_perr = 1'b0, p_ferr = 1'b0, p_ovf = 1'b0, p_valid = 1'b0;

  always @(negedge clk) begin
`ifdef PS2_RX_FIFO_EN
    if (rx.code_valid && rx.code_ready) begin
`else
    if (rx.code_valid) begin
`endif
      n_valid++;
      obs.push_back(rx.code);
    end
    if (rx.parity_err) n_perr++;
    if (rx.frame_err)  n_ferr++;
    if (rx.overflow)   n_ovf++;
    if ((p_perr && rx.parity_err) || (p_ferr && rx.frame_err) || (p_ovf && rx.overflow)) n_wide++;
`ifndef PS2_RX_FIFO_EN
    if (p_valid && rx.code_valid) n_wide++;
`endif
    p_perr  = rx.parity_err;
    p_ferr  = rx.frame_err;
    p_ovf   = rx.overflow;
    p_valid = rx.code_valid;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout simulation did not finish within 2 ms");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = bits[i];
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bits(frame_bits(d, p, s), 11);
    ps2_dat = 1'b1;
    wait_cycles(20);
  endtask

  // Outcome from frame rules: 0 good, 1 parity error, 2 framing error.
  function automatic int predict(input logic [7:0] d, input logic p, input logic s);
    if (!s) return 2;
    if (($countones({d, p}) % 2) == 0) return 1;
    return 0;
  endfunction

  task automatic run_frame(input string name, input logic [7:0] d, input logic p, input logic s,
                           input int ev, input int ep, input int ef, input logic [7:0] ec);
    int v0, pe0, fe0;
    v0 = n_valid; pe0 = n_perr; fe0 = n_ferr;
    obs.delete();
    send_frame(d, p, s);
    check({name, "_valid"}, n_valid - v0, ev);
    check({name, "_perr"}, n_perr - pe0, ep);
    check({name, "_ferr"}, n_ferr - fe0, ef);
    if (ev == 1) check({name, "_code"}, (obs.size() > 0) ? int'(obs[0]) : -1, int'(ec));
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         ev, ep, ef;
    logic [7:0] code;
  } tv_t;

  tv_t tv[7];

  initial begin
    int kind, n, v0, fe0;
    logic [7:0] d;
    logic p, s;
    logic [10:0] b;

    tv[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C};
    tv[1] = '{8'h1C, 1'b1, 1'b1, 0, 1, 0, 8'h00};
    tv[2] = '{8'hF0, 1'b1, 1'b1, 1, 0, 0, 8'hF0};
    tv[3] = '{8'h1C, 1'b0, 1'b0, 0, 0, 1, 8'h00};
    tv[4] = '{8'h00, 1'b1, 1'b1, 1, 0, 0, 8'h00};
    tv[5] = '{8'hFF, 1'b1, 1'b1, 1, 0, 0, 8'hFF};
    tv[6] = '{8'hFF, 1'b0, 1'b0, 0, 0, 1, 8'h00};

    rx.code_ready = 1'b1;
    wait_cycles(5);
    reset = 1'b0;
    wait_cycles(100);
    check("rst_code", int'(rx.code), 0);
    check("rst_flags", int'({rx.code_valid, rx.parity_err, rx.frame_err, rx.overflow}), 0);
    check("rst_events", n_valid + n_perr + n_ferr + n_ovf, 0);

    for (int i = 0; i < 7; i++) begin
      run_frame($sformatf("tv%0d", i), tv[i].data, tv[i].par, tv[i].stop,
                tv[i].ev, tv[i].ep, tv[i].ef, tv[i].code);
    end

    // Watchdog: abandon after 5 data bits; frame_err lands T cycles after the FSM sees the last fall.
    b = frame_bits(8'h1C, 1'b0, 1'b1);
    v0 = n_valid; fe0 = n_ferr;
    send_bits(b, 5);
    ps2_dat = b[5];
    wait_cycles(HALF);
    ps2_clk = 1'b0;
    n = 0;
    while (n < int'(T) + 100) begin
      @(negedge clk);
      n++;
      if (n == HALF) ps2_clk = 1'b1;
      if (rx.frame_err) break;
    end
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    check("wdog_latency", n, int'(T) + 3);
    wait_cycles(5);
    check("wdog_ferr", n_ferr - fe0, 1);
    check("wdog_valid", n_valid - v0, 0);
    run_frame("after_wdog", 8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C);

    // Reset in the middle of a frame.
    send_bits(frame_bits(8'h33, 1'b1, 1'b1), 5);
    ps2_dat = 1'b1;
    reset = 1'b1;
    wait_cycles(4);
    check("midrst_code", int'(rx.code), 0);
    check("midrst_flags", int'({rx.code_valid, rx.parity_err, rx.frame_err, rx.overflow}), 0);
    reset = 1'b0;
    wait_cycles(10);
    run_frame("after_rst", 8'h5A, 1'b1, 1'b1, 1, 0, 0, 8'h5A);

    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 4) != 0);
      kind = predict(d, p, s);
      run_frame($sformatf("rnd%0d", i), d, p, s,
                (kind == 0) ? 1 : 0, (kind == 1) ? 1 : 0, (kind == 2) ? 1 : 0, d);
      wait_cycles($urandom_range(5, 50));
    end

`ifdef PS2_RX_FIFO_EN
    begin
      int ov0;
      logic [7:0] q[$];
      obs.delete();
      @(posedge clk); #2 rx.code_ready = 1'b0;
      ov0 = n_ovf;
      for (int i = 1; i <= 4; i++) send_frame(8'(i), ~^(8'(i)), 1'b1);
      check("fifo_ovf_4", n_ovf - ov0, 0);
      check("fifo_head_valid", int'(rx.code_valid), 1);
      check("fifo_head_code", int'(rx.code), 1);
      send_frame(8'h05, ~^(8'h05), 1'b1);
      check("fifo_ovf_5", n_ovf - ov0, 1);
      check("fifo_no_pop", obs.size(), 0);
      @(posedge clk); #2 rx.code_ready = 1'b1;
      wait_cycles(10);
      q = obs;
      check("fifo_drain_n", q.size(), 4);
      for (int i = 0; i < 4; i++)
        check($sformatf("fifo_drain%0d", i), (q.size() > i) ? int'(q[i]) : -1, i + 1);
      check("fifo_empty", int'(rx.code_valid), 0);
    end
`endif

    check("pulse_width", n_wide, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_receiver.md
# ps2_receiver

- Deserialises the PS/2 clock/data pair driven by `keyboard_interface` into 8-bit scan codes for `Top`.
- Sits directly downstream of the keyboard model, in place of a physical keyboard port.
- Synchronises both PS/2 lines, frames start/data/parity/stop bits, and checks odd parity and the stop bit.
- Recovers from stalled frames with a watchdog and presents each good byte on a valid output, optionally buffered in a FIFO.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 50000: CLOCK_50 cycles without a ps2_clk falling edge before an open frame is abandoned (1 ms).
- `FIFO_DEPTH`, default 4: entries in the output FIFO; power of two, ≥2; used only with `PS2_RX_FIFO_EN`.

Ports:
- `CLOCK_50`, in, 1: sole clock, 50 MHz.
- `reset`, in, 1: synchronous, active-high.
- `ps2_clk`, in, 1: PS/2 clock, asynchronous to CLOCK_50.
- `ps2_dat`, in, 1: PS/2 data, asynchronous to CLOCK_50.
- `code`, out, 8: received scan code.
- `code_valid`, out, 1: `code` is valid.
- `code_ready`, in, 1: consumer accepts `code`; ignored without FIFO.
- `parity_err`, out, 1: one-cycle pulse, bad parity.
- `frame_err`, out, 1: one-cycle pulse, bad stop bit or timeout.
- `overflow`, out, 1: one-cycle pulse, good byte dropped because the FIFO is full.

One clock (CLOCK_50); reset is synchronous and active-high.

## Operation

- Both inputs pass through two flops, `s0`→`s1`. A third flop `clk_prev` holds the previous `s1` of ps2_clk.
- `fall = clk_prev & ~s1_clk`. All bit sampling uses `s1_dat` in the cycle `fall` is true.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with dat=0, go to DATA and clear bit count. On `fall` with dat=1, ignore and stay in IDLE.
  - DATA: on each `fall`, shift dat into bit [7] of the shift register (LSB-first frame). After the 8th bit, go to PARITY.
  - PARITY: on `fall`, store the parity bit and go to STOP.
  - STOP: on `fall`, always return to IDLE, then apply exactly one of these outcomes:
    - dat=0 → `frame_err` pulse; takes priority over the parity check.
    - dat=1 and the XOR of 8 data bits plus the parity bit is 0 (even total) → `parity_err` pulse.
    - otherwise → byte is good.
- Watchdog: a counter clears on every `fall` and in IDLE, and increments otherwise. When it reaches `TIMEOUT_CYCLES-1` in a non-IDLE state: `frame_err` pulse, return to IDLE, clear the counter.
- Errored frames never produce `code_valid`.
- Reset, including mid-frame:
  - FSM goes to IDLE; counters, shift register and FIFO clear.
  - Synchroniser flops load 1 (lines idle high).
  - All outputs 0.
  - Trailing edges of an interrupted frame are handled by the normal rules above; a 0 bit may be taken as a start bit, and the stop check or watchdog then resolves it.

## Timing

- Latency: `fall` is true in the cycle after the 2nd CLOCK_50 edge that samples ps2_clk low. The FSM acts on the 3rd such edge.
- For the stop bit, `code`/`code_valid` (or the error pulse) are visible after that 3rd edge.
- Without FIFO:
  - `code_valid` is a one-cycle pulse.
  - `code` holds its value until the next good byte.
- With FIFO:
  - `code_valid` stays high while the FIFO is non-empty.
- All error and overflow pulses are exactly one cycle wide.
- Minimum legal ps2_clk high and low time: 4 CLOCK_50 cycles.

## Configuration

- Macro: `PS2_RX_FIFO_EN`.
- Defined:
  - Good bytes are pushed into a FIFO of `FIFO_DEPTH` entries.
  - `code`/`code_valid` present the head entry (first-word fall-through).
  - The head is popped on a cycle with `code_valid & code_ready`.
  - Push while full and no pop: new byte dropped, `overflow` pulses.
  - Simultaneous push and pop while full: both succeed, no overflow.
  - Push into an empty FIFO: `code_valid` rises the following cycle.
- Undefined:
  - No FIFO; `code_ready` is ignored.
  - `overflow` is tied to 0.
  - Behaviour is the single-register pulse described under Timing.

## Test plan

- Reset, then idle lines high for 100 cycles → all outputs 0, no pulses.
- Frame 0x1C, parity bit 0, stop 1, 40-cycle half-period → exactly one `code_valid` with `code`=0x1C, no error pulses.
- Frame 0x1C with parity bit 1 → one `parity_err` pulse, no `code_valid`. Next, frame 0xF0 with parity bit 1 → `code`=0xF0 valid.
- Frame 0x1C with stop bit 0 → `frame_err` pulse. Abort after 5 data bits and hold idle for `TIMEOUT_CYCLES` → `frame_err` pulse at count `TIMEOUT_CYCLES-1`. Next, frame 0x1C → valid 0x1C.
- Assert reset after 4 data bits of a frame, release, then send 0x5A with parity 1 → outputs 0 during reset, then valid 0x5A.
- With `PS2_RX_FIFO_EN`, `code_ready`=0: send 0x01, 0x02, 0x03, 0x04, 0x05 → `overflow` pulses on the 5th. Raise `code_ready` → 0x01 through 0x04 popped in order, then `code_valid`=0.
